// File: rtl/sdp_ram_pipe_if.sv
// rtl/sdp_ram_pipe_if.sv - write/read port bundle for the pipelined simple-dual-port RAM
interface sdp_ram_pipe_if #(
    parameter int DATA_WIDTH = 72,
    parameter int ADDR_W     = 12
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  init_req;
    logic                  wea;
    logic [NB-1:0]         bwea;
    logic [ADDR_W-1:0]     addra;
    logic [DATA_WIDTH-1:0] dina;
    logic                  enb;
    logic [ADDR_W-1:0]     addrb;
    logic [DATA_WIDTH-1:0] doutb;
    logic                  doutb_valid;
    logic                  init_done;
    logic                  req_drop;

    modport master (
        output init_req, wea, bwea, addra, dina, enb, addrb,
        input  doutb, doutb_valid, init_done, req_drop
    );

    modport slave (
        input  init_req, wea, bwea, addra, dina, enb, addrb,
        output doutb, doutb_valid, init_done, req_drop
    );
endinterface

// File: rtl/sdp_ram_pipe.sv
// rtl/sdp_ram_pipe.sv - SDP RAM with byte enables, latency pipeline, collision mode and init engine
module sdp_ram_pipe #(
    parameter int                    DATA_WIDTH   = 72,
    parameter int                    DATA_DEPTH   = 4096,
    parameter int                    READ_LATENCY = 2,
    parameter bit                    WRITE_FIRST  = 1'b0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
    localparam int                   ADDR_W       = $clog2(DATA_DEPTH),
    localparam int                   NB           = DATA_WIDTH / 8
) (
    input  logic          clk,
    input  logic          rst_n,
    sdp_ram_pipe_if.slave bus
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_DEPTH - 1);

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     init_addr, init_addr_nxt;
    logic                  init_wr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  drop_nxt;
    logic                  req_drop_q;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    logic [DATA_WIDTH-1:0] pipe_d [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else begin
            state     <= state_nxt;
            init_addr <= init_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        init_addr_nxt = init_addr;
        init_wr       = 1'b0;
        wr_acc        = 1'b0;
        rd_acc        = 1'b0;
        drop_nxt      = 1'b0;
        case (state)
            ST_INIT: begin
                init_wr       = 1'b1;
                init_addr_nxt = init_addr + 1'b1;
                drop_nxt      = bus.wea | bus.enb;
                if (init_addr == LAST_ADDR) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                wr_acc = bus.wea;
                rd_acc = bus.enb;
                // This cycle's requests are still honoured; the clear starts next cycle.
                if (bus.init_req) begin
                    state_nxt     = ST_INIT;
                    init_addr_nxt = '0;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Array storage carries no reset so it maps onto block/ultra RAM.
    always_ff @(posedge clk) begin
        if (init_wr) begin
            mem[init_addr] <= INIT_VALUE;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.bwea[i]) begin
                    mem[bus.addra][8*i +: 8] <= bus.dina[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[bus.addrb];
        if (WRITE_FIRST && wr_acc && (bus.addra == bus.addrb)) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.bwea[i]) begin
                    rd_word[8*i +: 8] = bus.dina[8*i +: 8];
                end
            end
        end
    end

    // Data stages only advance behind a valid, so the last stage holds the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v     <= '0;
            req_drop_q <= 1'b0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_d[k] <= '0;
            end
        end else begin
            req_drop_q <= drop_nxt;
            pipe_v[0]  <= rd_acc;
            if (rd_acc) begin
                pipe_d[0] <= rd_word;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                if (pipe_v[k-1]) begin
                    pipe_d[k] <= pipe_d[k-1];
                end
            end
        end
    end

    assign bus.doutb       = pipe_d[READ_LATENCY-1];
    assign bus.doutb_valid = pipe_v[READ_LATENCY-1];
    assign bus.init_done   = (state == ST_RUN);
    assign bus.req_drop    = req_drop_q;
endmodule
